// File: rtl/id_ex_pkg.sv
// Shared types and defaults for the ID/EX pipeline stage.
package id_ex_pkg;

  localparam int EX_W_DEF = 7;
  localparam int M_W_DEF  = 4;
  localparam int WB_W_DEF = 2;
  localparam int RA_W_DEF = 5;

  // Control groups at their default widths; a zero value is a NOP bubble.
  typedef struct packed {
    logic [EX_W_DEF-1:0] ex;
    logic [M_W_DEF-1:0]  m;
    logic [WB_W_DEF-1:0] wb;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Occupancy of the two-entry buffer: M only, or M plus skid S.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry skid buffer: main entry M drives the output, skid
// entry S absorbs the beat accepted while downstream stalls. in_ready is
// decoded from the state register only, so it carries no combinational
// path from out_ready.
module pipe_skid_buf
  import id_ex_pkg::*;
#(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
);

  skid_state_e          state_q, state_d;
  logic [PAYLOAD_W-1:0] m_q, s_q;
  logic                 in_fire, out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign out_data = m_q;

  // State register; reset drops any held entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next-state: flush wins over both handshakes.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) state_d = ONE;
        ONE: begin
          if (in_fire && !out_fire)      state_d = FULL;
          else if (!in_fire && out_fire) state_d = EMPTY;
        end
        FULL:    if (out_fire) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
  end

  // Payload storage; entries are untouched on flush so data outputs hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
      s_q <= '0;
    end else if (!flush) begin
      case (state_q)
        EMPTY: if (in_fire) m_q <= in_data;
        ONE: begin
          if (in_fire && out_fire) m_q <= in_data;
          else if (in_fire)        s_q <= in_data;
        end
        FULL:    if (out_fire) m_q <= s_q;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline stage: packs decode fields into one payload, buffers it
// in a skid buffer, forces NOP control on bubbles and counts stall cycles.
module id_ex_pipe_stage
  import id_ex_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_OPS = 2,
  parameter int RA_W    = RA_W_DEF,
  parameter int EX_W    = EX_W_DEF,
  parameter int M_W     = M_W_DEF,
  parameter int WB_W    = WB_W_DEF,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_OPS*DATA_W-1:0] in_ops,
  input  logic [DATA_W-1:0]         in_offset,
  input  logic [RA_W-1:0]           in_rs,
  input  logic [RA_W-1:0]           in_rt,
  input  logic [RA_W-1:0]           in_rd,
  input  logic [EX_W-1:0]           in_ex,
  input  logic [M_W-1:0]            in_m,
  input  logic [WB_W-1:0]           in_wb,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_OPS*DATA_W-1:0] out_ops,
  output logic [DATA_W-1:0]         out_offset,
  output logic [RA_W-1:0]           out_rs,
  output logic [RA_W-1:0]           out_rt,
  output logic [RA_W-1:0]           out_rd,
  output logic [EX_W-1:0]           out_ex,
  output logic [M_W-1:0]            out_m,
  output logic [WB_W-1:0]           out_wb,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int PW = NUM_OPS*DATA_W + DATA_W + 3*RA_W + EX_W + M_W + WB_W;

  logic [PW-1:0]    pl_in, pl_out;
  logic [EX_W-1:0]  ex_raw;
  logic [M_W-1:0]   m_raw;
  logic [WB_W-1:0]  wb_raw;
  logic [CNT_W-1:0] stall_q, stall_d;

  assign pl_in = {in_ops, in_offset, in_rs, in_rt, in_rd, in_ex, in_m, in_wb};
  assign {out_ops, out_offset, out_rs, out_rt, out_rd, ex_raw, m_raw, wb_raw} = pl_out;

  pipe_skid_buf #(.PAYLOAD_W(PW)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pl_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pl_out)
  );

  // Bubbles must not carry stale control into EX.
  always_comb begin
    out_ex = out_valid ? ex_raw : '0;
    out_m  = out_valid ? m_raw  : '0;
    out_wb = out_valid ? wb_raw : '0;
  end

  // Saturating stall count; deliberately not cleared by flush.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != '1))
      stall_d = stall_q + CNT_W'(1);
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Bench for id_ex_pipe_stage: directed vector table, reset/saturation
// sequences, then a randomized run against a queue-based model.
module tb_id_ex_pipe_stage;

  localparam int DW = 64, NO = 3, RA = 5, EXW = 7, MW = 4, WBW = 2, CW = 4;
  localparam int SAT = (1 << CW) - 1;

  typedef struct packed {
    logic [NO*DW-1:0] ops;
    logic [DW-1:0]    off;
    logic [RA-1:0]    rs;
    logic [RA-1:0]    rt;
    logic [RA-1:0]    rd;
    logic [EXW-1:0]   ex;
    logic [MW-1:0]    m;
    logic [WBW-1:0]   wb;
  } beat_t;

  typedef struct {
    bit iv; int ib; bit ordy; bit fl;
    bit eov; bit eir; int eb; int est;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  beat_t in_b;
  logic [NO*DW-1:0] out_ops;
  logic [DW-1:0]    out_offset;
  logic [RA-1:0]    out_rs, out_rt, out_rd;
  logic [EXW-1:0]   out_ex;
  logic [MW-1:0]    out_m;
  logic [WBW-1:0]   out_wb;
  logic [CW-1:0]    stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_pipe_stage #(
    .DATA_W(DW), .NUM_OPS(NO), .RA_W(RA), .EX_W(EXW), .M_W(MW), .WB_W(WBW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ops(in_b.ops), .in_offset(in_b.off), .in_rs(in_b.rs), .in_rt(in_b.rt),
    .in_rd(in_b.rd), .in_ex(in_b.ex), .in_m(in_b.m), .in_wb(in_b.wb),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_ops(out_ops), .out_offset(out_offset), .out_rs(out_rs), .out_rt(out_rt),
    .out_rd(out_rd), .out_ex(out_ex), .out_m(out_m), .out_wb(out_wb),
    .stall_cnt(stall_cnt)
  );

  // Beat b: op0 = b*0x11, op1 = b*0x22, op2 = b*0x44; other fields tagged by b.
  function automatic beat_t mk(int b);
    beat_t x;
    x.ops = {64'(b * 32'h44), 64'(b * 32'h22), 64'(b * 32'h11)};
    x.off = 64'hF000_0000_0000_0000 | 64'(b);
    x.rs  = 5'(b);
    x.rt  = 5'(b + 1);
    x.rd  = 5'(b + 2);
    x.ex  = 7'h15;
    x.m   = 4'(b);
    x.wb  = 2'(b);
    return x;
  endfunction

  function automatic beat_t rnd();
    beat_t x;
    x.ops = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    x.off = {$urandom(), $urandom()};
    x.rs  = 5'($urandom());
    x.rt  = 5'($urandom());
    x.rd  = 5'($urandom());
    x.ex  = 7'($urandom());
    x.m   = 4'($urandom());
    x.wb  = 2'($urandom());
    return x;
  endfunction

  task automatic chk(input string nm, input logic [511:0] a, input logic [511:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic check_all(input string tag, input bit eov, input bit eir, input int est,
                           input beat_t eb);
    chk({tag, " out_valid"}, 512'(out_valid), 512'(eov));
    chk({tag, " in_ready"},  512'(in_ready),  512'(eir));
    chk({tag, " stall_cnt"}, 512'(stall_cnt), 512'(est));
    chk({tag, " data"}, 512'({out_ops, out_offset, out_rs, out_rt, out_rd}),
        512'({eb.ops, eb.off, eb.rs, eb.rt, eb.rd}));
    chk({tag, " ctrl"}, 512'({out_ex, out_m, out_wb}),
        512'(eov ? {eb.ex, eb.m, eb.wb} : 13'd0));
  endtask

  vec_t  tbl[15];
  beat_t q[$];
  beat_t last;
  int    cnt;

  initial begin
    // inputs: iv, beat, out_ready, flush | expected after edge: ov, ir, beat, stall
    tbl[0]  = '{1, 1, 1, 0,  1, 1, 1, 0};
    tbl[1]  = '{1, 2, 1, 0,  1, 1, 2, 0};
    tbl[2]  = '{1, 3, 1, 0,  1, 1, 3, 0};
    tbl[3]  = '{1, 4, 1, 0,  1, 1, 4, 0};
    tbl[4]  = '{1, 5, 1, 0,  1, 1, 5, 0};
    tbl[5]  = '{1, 6, 0, 0,  1, 0, 5, 1};
    tbl[6]  = '{1, 7, 0, 0,  1, 0, 5, 2};
    tbl[7]  = '{1, 7, 0, 0,  1, 0, 5, 3};
    tbl[8]  = '{1, 7, 1, 0,  1, 1, 6, 3};
    tbl[9]  = '{1, 7, 1, 0,  1, 1, 7, 3};
    tbl[10] = '{0, 7, 1, 0,  0, 1, 7, 3};
    tbl[11] = '{1, 8, 0, 0,  1, 1, 8, 3};
    tbl[12] = '{1, 9, 0, 0,  1, 0, 8, 4};
    tbl[13] = '{1, 10, 0, 1, 0, 1, 8, 5};
    tbl[14] = '{0, 0, 1, 0,  0, 1, 8, 5};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_b = '0;
    repeat (2) @(negedge clk);
    check_all("reset", 1'b0, 1'b1, 0, '0);
    rst_n = 1'b1;

    // Pass-through, back-pressure and flush-in-FULL vectors.
    for (int i = 0; i < 15; i++) begin
      in_valid  = tbl[i].iv;
      in_b      = mk(tbl[i].ib);
      out_ready = tbl[i].ordy;
      flush     = tbl[i].fl;
      @(negedge clk);
      check_all($sformatf("vec%0d", i), tbl[i].eov, tbl[i].eir, tbl[i].est, mk(tbl[i].eb));
    end

    // Fill to FULL, then reset asynchronously between edges.
    in_valid = 1'b1; in_b = mk(11); out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    check_all("fill1", 1'b1, 1'b1, 5, mk(11));
    in_b = mk(12);
    @(negedge clk);
    check_all("fill2", 1'b1, 1'b0, 6, mk(11));
    #2 rst_n = 1'b0;
    #1 check_all("async_rst", 1'b0, 1'b1, 0, '0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; in_b = mk(13); out_ready = 1'b1;
    @(negedge clk);
    check_all("post_rst", 1'b1, 1'b1, 0, mk(13));

    // Stall counter saturation.
    in_b = mk(14); out_ready = 1'b0;
    repeat (14) @(negedge clk);
    check_all("sat14", 1'b1, 1'b0, 14, mk(13));
    repeat (6) @(negedge clk);
    check_all("sat_cap", 1'b1, 1'b0, SAT, mk(13));

    // Randomized run against a queue model.
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete(); last = '0; cnt = 0;
    for (int c = 0; c < 1000; c++) begin
      bit cur_v, cur_r;
      check_all($sformatf("rnd%0d", c), q.size() != 0, q.size() < 2, cnt, last);
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 65);
      flush     = ($urandom_range(0, 99) < 3);
      in_b      = rnd();
      cur_v = (q.size() != 0);
      cur_r = (q.size() < 2);
      if (cur_v && !out_ready && cnt < SAT) cnt++;
      if (flush) q.delete();
      else begin
        if (cur_v && out_ready) void'(q.pop_front());
        if (in_valid && cur_r) q.push_back(in_b);
      end
      if (q.size() != 0) last = q[0];
      @(negedge clk);
    end
    check_all("rnd_end", q.size() != 0, q.size() < 2, cnt, last);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
